multiphase_buck_ctrl: RTL and testbench
=======================================

Name: multiphase_buck_ctrl

Overview:
- N-phase interleaved buck pulse controller for the EDM pulse power stage. It generalises the two-phase buck controller to N_PHASE phases with evenly spaced carriers.
- Sequence per discharge: wait for gap breakdown, run the interleaved current pulse for ton, then deionise for toff.
- Adds a latched overcurrent fault with filter and explicit clear, and a per-pulse toff counter replacing the free-running Ts timer.
- Sits between the ADC front end and the MOSFET gate drivers.

Parameters:
- N_PHASE, 4, number of buck phases (2..8).
- PERIOD, 200, interleave carrier period in clk cycles (4 us at 50 MHz).
- DEAD_TIME, 5, dead time between upper and lower gate in cycles.
- T_WAIT_MIN, 50, earliest valid breakdown cycle count.
- T_WAIT_MAX, 250, breakdown timeout in cycles.
- OC_FILTER, 3, consecutive over-limit samples needed to trip the fault.
- AD_W, 12, ADC sample width.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset
- power_start  in  1  machining enable
- fault_clr  in  1  clears a latched fault; accepted only while power_start=0
- ton  in  16  pulse on-time in cycles
- toff  in  16  deionisation time in cycles
- rise_time  in  7  upper-FET on-time per carrier period
- brk_cur  in  AD_W  breakdown current threshold
- brk_vol  in  AD_W  breakdown voltage threshold
- oc_limit  in  AD_W  overcurrent threshold
- ad_cur  in  AD_W  gap current sample
- ad_vol  in  AD_W  gap voltage sample
- short_flag  in  1  short-circuit class from the pulse sorter
- mos_buck  out  2*N_PHASE  per phase {upper,lower}; phase k occupies bits [2k+1:2k]
- mos_res  out  2  resistive pre-charge leg {upper,lower}
- mos_deion  out  1  deionisation switch
- occ_flag  out  1  high while in INTERLEAVE
- occ_cnt  out  16  cycles spent in the current INTERLEAVE
- fault  out  1  latched overcurrent
- state  out  3  current FSM state, for debug

Behaviour:
- Reset applies on a clk edge with rst_n=0. All outputs are 0 and the FSM enters IDLE.
- FSM states: IDLE, WAIT_BREAK, INTERLEAVE, T_OFF, FAULT.
- Outputs are registered and decoded from the next-state value, so they change in the same cycle as state.
- IDLE: all switches off. Leave for WAIT_BREAK when power_start=1 and fault=0.
- WAIT_BREAK:
  - mos_res=10, cnt_wait increments by 1 per cycle.
  - If T_WAIT_MIN<cnt_wait<T_WAIT_MAX and ad_cur>=brk_cur and ad_vol<brk_vol, go to INTERLEAVE.
  - Else if cnt_wait>=T_WAIT_MAX, go to T_OFF.
- INTERLEAVE:
  - First cycle: all switches off (entry gap).
  - The carrier counts 0..PERIOD-1 and wraps. SLOT=PERIOD/N_PHASE, truncated.
  - Phase k is inactive (00) until the carrier first reaches k*SLOT.
  - After that, phase k uses local time t=(carrier-k*SLOT) mod PERIOD:
    - t<DEAD: 00
    - t<DEAD+rt: 10
    - t<2*DEAD+rt: 00
    - otherwise: 01
  - rt is rise_time clamped to PERIOD-2*DEAD_TIME-1.
  - occ_cnt increments each cycle. Exit to T_OFF when occ_cnt>=ton.
- T_OFF:
  - mos_deion=1, mos_res=00, occ_cnt cleared.
  - All phases drive 01, except 00 during the first DEAD_TIME and last DEAD_TIME cycles of the interval.
  - Exit to WAIT_BREAK when cnt_off>=toff.
  - If toff<2*DEAD_TIME, all phases stay 00 for the whole interval.
- mos_deion is 0 in every state other than T_OFF.
- Overcurrent:
  - oc_cnt increments while ad_cur>oc_limit and resets to 0 otherwise, saturating at OC_FILTER.
  - Reaching OC_FILTER takes the FSM to FAULT from any state in the following cycle.
  - FAULT: all switches 0 and fault=1. Leave to IDLE only when fault_clr=1 and power_start=0.
- power_start=0 in any non-FAULT state sends the FSM to IDLE next cycle. All counters clear and all switches go to 0.
- Simultaneous events: FAULT outranks power_start loss, which outranks normal transitions.
- ton=0: a single off cycle in INTERLEAVE, then T_OFF.

Optional Feature:
- SHORT_ABORT_EN defined: short_flag=1 during INTERLEAVE forces T_OFF next cycle and sets occ_cnt to 0.
- Undefined: short_flag is ignored.

Decomposition:
- Shared package buck_pkg holds:
  - the state enum encoding (IDLE=0, WAIT_BREAK=1, INTERLEAVE=2, T_OFF=3, FAULT=4)
  - the gate pattern constants GATE_OFF=00, GATE_UP=10, GATE_DN=01
- Natural sub-module: buck_phase_gate. Inputs are local time t, rt, DEAD_TIME and an active flag; output is the 2-bit gate. It is instantiated N_PHASE times in a generate loop.

Test Plan:
- Breakdown: power_start=1, ad_cur=400 and ad_vol=300 applied at cnt_wait=60 -> INTERLEAVE at the next edge; mos_buck all 0 on the first cycle; mos_res goes 10->00.
- Interleave timing, N_PHASE=4 and rise_time=20: phase k upper is high for carrier in [50k+5, 50k+25) and lower from 50k+30; no phase ever shows 11.
- Timeout: no breakdown -> T_OFF at cnt_wait=250; mos_deion=1; WAIT_BREAK again after toff=100 cycles.
- Overcurrent: ad_cur>oc_limit for 2 cycles -> no fault. For 3 cycles -> FAULT, all gates 0. fault_clr with power_start=1 is ignored; with power_start=0 -> IDLE.
- Mid-pulse: rst_n=0 or power_start=0 at occ_cnt=37 -> all outputs 0 at the next edge, occ_cnt=0.
- With SHORT_ABORT_EN, short_flag pulse at occ_cnt=10 -> T_OFF next cycle. Without the macro, the pulse runs to occ_cnt=ton.

Source files
------------

// File: rtl/buck_pkg.sv
// Shared definitions for the multiphase buck pulse controller.
//
// Contents:
//   buck_state_e  controller FSM state encoding (also exported on the debug port)
//   GATE_*        2-bit gate patterns, ordered {upper, lower}
package buck_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BREAK = 3'd1,
    INTERLEAVE = 3'd2,
    T_OFF      = 3'd3,
    FAULT      = 3'd4
  } buck_state_e;

  localparam logic [1:0] GATE_OFF = 2'b00;
  localparam logic [1:0] GATE_UP  = 2'b10;
  localparam logic [1:0] GATE_DN  = 2'b01;

endpackage

// File: rtl/buck_phase_gate.sv
// Gate pattern decoder for one buck phase.
//
// Maps the phase-local carrier time to an {upper, lower} gate pair. There is
// dead time before the upper pulse, upper on for rt cycles, dead time again,
// then lower on for the rest of the period. An inactive phase is held off.
//
// Parameters:
//   CAR_W      carrier / local time width
//   DEAD_TIME  dead time in cycles
// Ports:
//   t       in   CAR_W  phase-local carrier time
//   rt      in   CAR_W  upper-FET on-time, already clamped by the caller
//   active  in   1      phase has started in this INTERLEAVE interval
//   gate    out  2      {upper, lower}
module buck_phase_gate
  import buck_pkg::*;
#(
  parameter int CAR_W     = 8,
  parameter int DEAD_TIME = 5
) (
  input  logic [CAR_W-1:0] t,
  input  logic [CAR_W-1:0] rt,
  input  logic             active,
  output logic [1:0]       gate
);

  localparam logic [CAR_W:0] DEAD_X = (CAR_W+1)'(DEAD_TIME);

  // One extra bit so that dead + rt + dead cannot wrap.
  logic [CAR_W:0] t_x;
  logic [CAR_W:0] up_end;
  logic [CAR_W:0] dn_start;

  assign t_x      = {1'b0, t};
  assign up_end   = DEAD_X + {1'b0, rt};
  assign dn_start = up_end + DEAD_X;

  always_comb begin
    gate = GATE_OFF;
    if (active) begin
      if (t_x < DEAD_X)        gate = GATE_OFF;
      else if (t_x < up_end)   gate = GATE_UP;
      else if (t_x < dn_start) gate = GATE_OFF;
      else                     gate = GATE_DN;
    end
  end

endmodule

// File: rtl/multiphase_buck_ctrl.sv
// N-phase interleaved buck pulse controller for the EDM pulse power stage.
//
// Per discharge: wait for gap breakdown (resistive pre-charge leg on), run the
// interleaved current pulse for ton cycles, then deionise for toff cycles.
// A filtered overcurrent detector latches a fault that needs an explicit clear.
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
//
// Build option: define SHORT_ABORT_EN to let short_flag end INTERLEAVE early;
// without it short_flag is ignored.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   power_start          machining enable
//   fault_clr            clears latched fault while power_start=0
//   ton, toff            pulse on / deionisation times in cycles
//   rise_time            upper-FET on-time per carrier period
//   brk_cur, brk_vol     breakdown thresholds
//   oc_limit             overcurrent threshold
//   ad_cur, ad_vol       gap current / voltage samples
//   short_flag           short-circuit class from the pulse sorter
//   mos_buck             per phase {upper,lower}, phase k at [2k+1:2k]
//   mos_res              pre-charge leg {upper,lower}
//   mos_deion            deionisation switch
//   occ_flag, occ_cnt    INTERLEAVE indicator and its cycle count
//   fault                latched overcurrent
//   state                FSM state for debug
module multiphase_buck_ctrl
  import buck_pkg::*;
#(
  parameter int N_PHASE    = 4,
  parameter int PERIOD     = 200,
  parameter int DEAD_TIME  = 5,
  parameter int T_WAIT_MIN = 50,
  parameter int T_WAIT_MAX = 250,
  parameter int OC_FILTER  = 3,
  parameter int AD_W       = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 power_start,
  input  logic                 fault_clr,
  input  logic [15:0]          ton,
  input  logic [15:0]          toff,
  input  logic [6:0]           rise_time,
  input  logic [AD_W-1:0]      brk_cur,
  input  logic [AD_W-1:0]      brk_vol,
  input  logic [AD_W-1:0]      oc_limit,
  input  logic [AD_W-1:0]      ad_cur,
  input  logic [AD_W-1:0]      ad_vol,
  input  logic                 short_flag,
  output logic [2*N_PHASE-1:0] mos_buck,
  output logic [1:0]           mos_res,
  output logic                 mos_deion,
  output logic                 occ_flag,
  output logic [15:0]          occ_cnt,
  output logic                 fault,
  output logic [2:0]           state
);

  localparam int SLOT  = PERIOD / N_PHASE;
  localparam int CAR_W = $clog2(PERIOD);
  localparam int OC_W  = $clog2(OC_FILTER + 1);

  localparam logic [15:0]      WAIT_MIN_C = 16'(T_WAIT_MIN);
  localparam logic [15:0]      WAIT_MAX_C = 16'(T_WAIT_MAX);
  localparam logic [15:0]      RT_MAX_C   = 16'(PERIOD - 2*DEAD_TIME - 1);
  localparam logic [16:0]      DEAD_X     = 17'(DEAD_TIME);
  localparam logic [CAR_W-1:0] CAR_LAST   = CAR_W'(PERIOD - 1);
  localparam logic [CAR_W:0]   PER_X      = (CAR_W+1)'(PERIOD);
  localparam logic [OC_W-1:0]  OC_MAX     = OC_W'(OC_FILTER);

  buck_state_e          state_q, state_d;
  logic [15:0]          cnt_wait_q, cnt_wait_d;
  logic [15:0]          occ_cnt_q, occ_cnt_d;
  logic [15:0]          cnt_off_q, cnt_off_d;
  logic [CAR_W-1:0]     carrier_q, carrier_d;
  logic                 car_run_q, car_run_d;
  logic [N_PHASE-1:0]   active_q, active_d;
  logic [OC_W-1:0]      oc_cnt_q, oc_cnt_d;
  logic [2*N_PHASE-1:0] mos_buck_q, mos_buck_d;
  logic [1:0]           mos_res_q, mos_res_d;
  logic                 mos_deion_q, mos_deion_d;
  logic                 occ_flag_q, occ_flag_d;
  logic                 fault_q, fault_d;

  logic [2*N_PHASE-1:0] phase_gate;
  logic [CAR_W-1:0]     rt;
  logic [15:0]          rt_wide;
  logic                 oc_trip;
  logic                 short_abort;
  logic                 stay_il;
  logic                 toff_on;

`ifdef SHORT_ABORT_EN
  assign short_abort = short_flag;
`else
  logic unused_short_flag;
  assign unused_short_flag = short_flag;
  assign short_abort       = 1'b0;
`endif

  assign rt_wide = {9'd0, rise_time};
  assign rt      = CAR_W'((rt_wide > RT_MAX_C) ? RT_MAX_C : rt_wide);
  assign oc_trip = (oc_cnt_q == OC_MAX);

  // Overcurrent filter: consecutive over-limit samples, saturating.
  always_comb begin
    oc_cnt_d = '0;
    if (ad_cur > oc_limit) begin
      oc_cnt_d = (oc_cnt_q == OC_MAX) ? oc_cnt_q : oc_cnt_q + OC_W'(1);
    end
  end

  // Next-state logic; a tripped filter wins over everything, then loss of
  // power_start, then the normal discharge sequence.
  always_comb begin
    state_d = state_q;
    if (oc_trip) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      if (fault_clr && !power_start) state_d = IDLE;
    end else if (!power_start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fault_q) state_d = WAIT_BREAK;
        end
        WAIT_BREAK: begin
          if (cnt_wait_q > WAIT_MIN_C && cnt_wait_q < WAIT_MAX_C &&
              ad_cur >= brk_cur && ad_vol < brk_vol) begin
            state_d = INTERLEAVE;
          end else if (cnt_wait_q >= WAIT_MAX_C) begin
            state_d = T_OFF;
          end
        end
        INTERLEAVE: begin
          if (short_abort || occ_cnt_q >= ton) state_d = T_OFF;
        end
        T_OFF: begin
          if (cnt_off_q >= toff) state_d = WAIT_BREAK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-state counters start at 0 on entry and clear whenever the state is
  // left. The carrier starts one cycle after INTERLEAVE entry so the entry
  // cycle is an all-off gap.
  always_comb begin
    stay_il    = (state_d == INTERLEAVE) && (state_q == INTERLEAVE);
    cnt_wait_d = ((state_d == WAIT_BREAK) && (state_q == WAIT_BREAK)) ?
                 cnt_wait_q + 16'd1 : 16'd0;
    cnt_off_d  = ((state_d == T_OFF) && (state_q == T_OFF)) ?
                 cnt_off_q + 16'd1 : 16'd0;
    occ_cnt_d  = stay_il ? occ_cnt_q + 16'd1 : 16'd0;
    car_run_d  = stay_il;
    carrier_d  = '0;
    if (stay_il && car_run_q) begin
      carrier_d = (carrier_q == CAR_LAST) ? '0 : carrier_q + CAR_W'(1);
    end
  end

  // Phase k starts when the carrier first reaches k*SLOT and then runs on
  // its own time base, shifted by k*SLOT modulo the period.
  for (genvar k = 0; k < N_PHASE; k++) begin : g_phase
    localparam logic [CAR_W-1:0] OFF_C = CAR_W'(k * SLOT);
    localparam logic [CAR_W:0]   OFF_X = (CAR_W+1)'(k * SLOT);
    logic [CAR_W:0]   sum;
    logic [CAR_W-1:0] t_loc;

    assign active_d[k] = car_run_d && (active_q[k] || carrier_d == OFF_C);
    assign sum         = {1'b0, carrier_d} + (PER_X - OFF_X);
    assign t_loc       = (sum >= PER_X) ? CAR_W'(sum - PER_X) : CAR_W'(sum);

    buck_phase_gate #(
      .CAR_W     (CAR_W),
      .DEAD_TIME (DEAD_TIME)
    ) u_gate (
      .t      (t_loc),
      .rt     (rt),
      .active (active_d[k]),
      .gate   (phase_gate[2*k+1:2*k])
    );
  end

  // Low FETs freewheel during deionisation, with a dead band at each end.
  assign toff_on = ({1'b0, cnt_off_d} >= DEAD_X) &&
                   ({1'b0, cnt_off_d} + DEAD_X <= {1'b0, toff});

  // Output decode from the next state.
  always_comb begin
    mos_buck_d  = '0;
    mos_res_d   = GATE_OFF;
    mos_deion_d = 1'b0;
    occ_flag_d  = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      WAIT_BREAK: mos_res_d = GATE_UP;
      INTERLEAVE: begin
        mos_buck_d = phase_gate;
        occ_flag_d = 1'b1;
      end
      T_OFF: begin
        mos_deion_d = 1'b1;
        if (toff_on) mos_buck_d = {N_PHASE{GATE_DN}};
      end
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_wait_q  <= '0;
      occ_cnt_q   <= '0;
      cnt_off_q   <= '0;
      carrier_q   <= '0;
      car_run_q   <= 1'b0;
      active_q    <= '0;
      oc_cnt_q    <= '0;
      mos_buck_q  <= '0;
      mos_res_q   <= '0;
      mos_deion_q <= 1'b0;
      occ_flag_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_wait_q  <= cnt_wait_d;
      occ_cnt_q   <= occ_cnt_d;
      cnt_off_q   <= cnt_off_d;
      carrier_q   <= carrier_d;
      car_run_q   <= car_run_d;
      active_q    <= active_d;
      oc_cnt_q    <= oc_cnt_d;
      mos_buck_q  <= mos_buck_d;
      mos_res_q   <= mos_res_d;
      mos_deion_q <= mos_deion_d;
      occ_flag_q  <= occ_flag_d;
      fault_q     <= fault_d;
    end
  end

  assign mos_buck  = mos_buck_q;
  assign mos_res   = mos_res_q;
  assign mos_deion = mos_deion_q;
  assign occ_flag  = occ_flag_q;
  assign occ_cnt   = occ_cnt_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multiphase_buck_ctrl.sv
// Directed testbench for multiphase_buck_ctrl with default parameters
// (4 phases, 200-cycle carrier, dead time 5, rise_time 20).
// Inputs change 1 time unit after each rising edge and outputs are sampled
// there, so every sample shows the state registered by the preceding edge.
module tb_multiphase_buck_ctrl;

  localparam int N_PHASE = 4;
  localparam int AD_W    = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 power_start;
  logic                 fault_clr;
  logic [15:0]          ton;
  logic [15:0]          toff;
  logic [6:0]           rise_time;
  logic [AD_W-1:0]      brk_cur;
  logic [AD_W-1:0]      brk_vol;
  logic [AD_W-1:0]      oc_limit;
  logic [AD_W-1:0]      ad_cur;
  logic [AD_W-1:0]      ad_vol;
  logic                 short_flag;
  logic [2*N_PHASE-1:0] mos_buck;
  logic [1:0]           mos_res;
  logic                 mos_deion;
  logic                 occ_flag;
  logic [15:0]          occ_cnt;
  logic                 fault;
  logic [2:0]           state;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view of the outputs: {state, mos_buck, mos_res, deion, occ_flag, fault}.
  wire [15:0] obs = {state, mos_buck, mos_res, mos_deion, occ_flag, fault};

  always #5 clk = ~clk;

  multiphase_buck_ctrl #(
    .N_PHASE    (N_PHASE),
    .PERIOD     (200),
    .DEAD_TIME  (5),
    .T_WAIT_MIN (50),
    .T_WAIT_MAX (250),
    .OC_FILTER  (3),
    .AD_W       (AD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power_start (power_start),
    .fault_clr   (fault_clr),
    .ton         (ton),
    .toff        (toff),
    .rise_time   (rise_time),
    .brk_cur     (brk_cur),
    .brk_vol     (brk_vol),
    .oc_limit    (oc_limit),
    .ad_cur      (ad_cur),
    .ad_vol      (ad_vol),
    .short_flag  (short_flag),
    .mos_buck    (mos_buck),
    .mos_res     (mos_res),
    .mos_deion   (mos_deion),
    .occ_flag    (occ_flag),
    .occ_cnt     (occ_cnt),
    .fault       (fault),
    .state       (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected gates for INTERLEAVE cycle n (occ_cnt=n, carrier=n-1 mod 200),
  // rise_time 20: upper for local t in [5,25), lower from t=30.
  function automatic logic [7:0] exp_buck(int n);
    logic [7:0] r;
    int c, t;
    r = 8'h00;
    c = (n - 1) % 200;
    for (int k = 0; k < 4; k++) begin
      if (n - 1 >= 50 * k) begin
        t = (c - 50 * k + 200) % 200;
        if (t < 5)       r[2*k +: 2] = 2'b00;
        else if (t < 25) r[2*k +: 2] = 2'b10;
        else if (t < 30) r[2*k +: 2] = 2'b00;
        else             r[2*k +: 2] = 2'b01;
      end
    end
    return r;
  endfunction

  task automatic breakdown_on();
    ad_cur = 12'd400;
    ad_vol = 12'd300;
  endtask

  task automatic breakdown_off();
    ad_cur = 12'd0;
    ad_vol = 12'd1000;
  endtask

  // Takes the controller from IDLE to the INTERLEAVE entry cycle.
  task automatic enter_interleave();
    power_start = 1'b1;
    tick();
    repeat (60) tick();
    breakdown_on();
    tick();
    breakdown_off();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (obs !== 16'h0000 || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL reset_outputs: got obs=%h occ=%0d, expected obs=0000 occ=0", obs, occ_cnt);
      n_fail++;
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== 16'h0000) begin
      $display("[TB] FAIL idle_hold: got %h, expected 0000", obs);
      n_fail++;
    end
  endtask

  task automatic test_breakdown();
    power_start = 1'b1;
    tick();
    n_checks++;
    if (obs !== {3'd1, 8'h00, 2'b10, 3'b000}) begin
      $display("[TB] FAIL wait_entry: got %h, expected %h", obs, {3'd1, 8'h00, 2'b10, 3'b000});
      n_fail++;
    end
    repeat (50) tick();
    breakdown_on();
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      $display("[TB] FAIL break_at_min: got state %0d, expected 1", state);
      n_fail++;
    end
    breakdown_off();
    repeat (9) tick();
    n_checks++;
    if (state !== 3'd1) begin
      $display("[TB] FAIL wait_at_60: got state %0d, expected 1", state);
      n_fail++;
    end
    breakdown_on();
    tick();
    n_checks++;
    if (obs !== {3'd2, 8'h00, 2'b00, 3'b010} || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL break_entry: got obs=%h occ=%0d, expected obs=%h occ=0", obs, occ_cnt, {3'd2, 8'h00, 2'b00, 3'b010});
      n_fail++;
    end
  endtask

  task automatic test_interleave();
    breakdown_off();
    for (int n = 1; n <= 450; n++) begin
      tick();
      n_checks++;
      if (state !== 3'd2 || occ_cnt !== 16'(n) || mos_buck !== exp_buck(n)) begin
        $display("[TB] FAIL interleave_n%0d: got state=%0d occ=%0d buck=%h, expected state=2 occ=%0d buck=%h", n, state, occ_cnt, mos_buck, n, exp_buck(n));
        n_fail++;
      end
      n_checks++;
      if ((mos_buck & (mos_buck >> 1) & 8'h55) !== 8'h00) begin
        $display("[TB] FAIL shoot_through_n%0d: got buck=%h, expected no 11 pair", n, mos_buck);
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (obs !== {3'd3, 8'h00, 2'b00, 3'b100} || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL ton_exit: got obs=%h occ=%0d, expected obs=%h occ=0", obs, occ_cnt, {3'd3, 8'h00, 2'b00, 3'b100});
      n_fail++;
    end
    for (int c = 1; c <= 100; c++) begin
      tick();
      n_checks++;
      if (obs !== {3'd3, ((c >= 5 && c <= 95) ? 8'h55 : 8'h00), 2'b00, 3'b100}) begin
        $display("[TB] FAIL toff_c%0d: got %h, expected %h", c, obs, {3'd3, ((c >= 5 && c <= 95) ? 8'h55 : 8'h00), 2'b00, 3'b100});
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (obs !== {3'd1, 8'h00, 2'b10, 3'b000}) begin
      $display("[TB] FAIL toff_exit: got %h, expected %h", obs, {3'd1, 8'h00, 2'b10, 3'b000});
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    repeat (250) tick();
    n_checks++;
    if (state !== 3'd1) begin
      $display("[TB] FAIL wait_249: got state %0d, expected 1", state);
      n_fail++;
    end
    tick();
    n_checks++;
    if (obs !== {3'd3, 8'h00, 2'b00, 3'b100}) begin
      $display("[TB] FAIL timeout_entry: got %h, expected %h", obs, {3'd3, 8'h00, 2'b00, 3'b100});
      n_fail++;
    end
    repeat (100) tick();
    n_checks++;
    if (state !== 3'd3) begin
      $display("[TB] FAIL toff_last: got state %0d, expected 3", state);
      n_fail++;
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || mos_deion !== 1'b0) begin
      $display("[TB] FAIL timeout_rewait: got state=%0d deion=%b, expected state=1 deion=0", state, mos_deion);
      n_fail++;
    end
  endtask

  task automatic test_ton_zero();
    ton = 16'd0;
    repeat (60) tick();
    breakdown_on();
    tick();
    breakdown_off();
    n_checks++;
    if (state !== 3'd2 || mos_buck !== 8'h00 || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL ton0_entry: got state=%0d buck=%h occ=%0d, expected 2/00/0", state, mos_buck, occ_cnt);
      n_fail++;
    end
    tick();
    n_checks++;
    if (state !== 3'd3) begin
      $display("[TB] FAIL ton0_exit: got state %0d, expected 3", state);
      n_fail++;
    end
    power_start = 1'b0;
    tick();
    n_checks++;
    if (obs !== 16'h0000) begin
      $display("[TB] FAIL toff_power_loss: got %h, expected 0000", obs);
      n_fail++;
    end
    ton = 16'd450;
  endtask

  task automatic test_overcurrent();
    power_start = 1'b1;
    tick();
    ad_cur = 12'd3500;
    repeat (2) tick();
    ad_cur = 12'd0;
    repeat (2) tick();
    n_checks++;
    if (obs !== {3'd1, 8'h00, 2'b10, 3'b000}) begin
      $display("[TB] FAIL oc_two_samples: got %h, expected %h", obs, {3'd1, 8'h00, 2'b10, 3'b000});
      n_fail++;
    end
    ad_cur = 12'd3500;
    repeat (3) tick();
    n_checks++;
    if (state !== 3'd1 || fault !== 1'b0) begin
      $display("[TB] FAIL oc_filter_delay: got state=%0d fault=%b, expected 1/0", state, fault);
      n_fail++;
    end
    ad_cur = 12'd0;
    tick();
    n_checks++;
    if (obs !== {3'd4, 8'h00, 2'b00, 3'b001}) begin
      $display("[TB] FAIL oc_trip: got %h, expected %h", obs, {3'd4, 8'h00, 2'b00, 3'b001});
      n_fail++;
    end
    fault_clr = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      $display("[TB] FAIL clr_while_powered: got state=%0d fault=%b, expected 4/1", state, fault);
      n_fail++;
    end
    fault_clr   = 1'b0;
    power_start = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd4) begin
      $display("[TB] FAIL fault_latched: got state %0d, expected 4", state);
      n_fail++;
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_checks++;
    if (obs !== 16'h0000) begin
      $display("[TB] FAIL fault_clear: got %h, expected 0000", obs);
      n_fail++;
    end
  endtask

  task automatic test_midpulse_power();
    ton = 16'd450;
    enter_interleave();
    repeat (37) tick();
    n_checks++;
    if (occ_cnt !== 16'd37 || mos_buck !== 8'h01) begin
      $display("[TB] FAIL midpulse_37: got occ=%0d buck=%h, expected 37/01", occ_cnt, mos_buck);
      n_fail++;
    end
    power_start = 1'b0;
    tick();
    n_checks++;
    if (obs !== 16'h0000 || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL midpulse_power_loss: got obs=%h occ=%0d, expected 0000/0", obs, occ_cnt);
      n_fail++;
    end
  endtask

  task automatic test_midpulse_reset();
    enter_interleave();
    repeat (37) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (obs !== 16'h0000 || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL midpulse_reset: got obs=%h occ=%0d, expected 0000/0", obs, occ_cnt);
      n_fail++;
    end
    rst_n       = 1'b1;
    power_start = 1'b0;
    tick();
  endtask

  task automatic test_short_flag();
    ton = 16'd100;
    enter_interleave();
    repeat (10) tick();
    short_flag = 1'b1;
    tick();
    short_flag = 1'b0;
`ifdef SHORT_ABORT_EN
    n_checks++;
    if (state !== 3'd3 || occ_cnt !== 16'd0 || mos_deion !== 1'b1) begin
      $display("[TB] FAIL short_abort: got state=%0d occ=%0d deion=%b, expected 3/0/1", state, occ_cnt, mos_deion);
      n_fail++;
    end
`else
    n_checks++;
    if (state !== 3'd2 || occ_cnt !== 16'd11) begin
      $display("[TB] FAIL short_ignored: got state=%0d occ=%0d, expected 2/11", state, occ_cnt);
      n_fail++;
    end
    repeat (89) tick();
    n_checks++;
    if (state !== 3'd2 || occ_cnt !== 16'd100) begin
      $display("[TB] FAIL short_full_pulse: got state=%0d occ=%0d, expected 2/100", state, occ_cnt);
      n_fail++;
    end
    tick();
    n_checks++;
    if (state !== 3'd3 || occ_cnt !== 16'd0) begin
      $display("[TB] FAIL short_ton_exit: got state=%0d occ=%0d, expected 3/0", state, occ_cnt);
      n_fail++;
    end
`endif
    power_start = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      $display("[TB] FAIL short_shutdown: got state %0d, expected 0", state);
      n_fail++;
    end
  endtask

  // Scenario sequence; each test starts from the state the previous one left.
  initial begin
    rst_n       = 1'b0;
    power_start = 1'b0;
    fault_clr   = 1'b0;
    short_flag  = 1'b0;
    ton         = 16'd450;
    toff        = 16'd100;
    rise_time   = 7'd20;
    brk_cur     = 12'd300;
    brk_vol     = 12'd500;
    oc_limit    = 12'd3000;
    breakdown_off();
    $display("[TB] starting multiphase_buck_ctrl bench");
    test_reset();
    test_breakdown();
    test_interleave();
    test_timeout();
    test_ton_zero();
    test_overcurrent();
    test_midpulse_power();
    test_midpulse_reset();
    test_short_flag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
